// File: rtl/sme_pkg.sv
// Shared constants and FSM encoding for the SME host feeder.
package sme_pkg;
  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;

  localparam logic [7:0] TRIANGLE = 8'd94;
  localparam logic [7:0] MONEY    = 8'd36;
  localparam logic [7:0] DOT      = 8'd46;
  localparam logic [7:0] STAR     = 8'd42;
  localparam logic [7:0] SPACE    = 8'd32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_STR,
    S_SEND_PAT,
    S_WAIT,
    S_RESULT
  } state_t;
endpackage

// File: rtl/sme_char_buf.sv
// DEPTH x 8 character store: one synchronous write port, one asynchronous read port.
module sme_char_buf #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sme_host_feeder.sv
// Serializes a buffered string and pattern onto the SME char bus, then returns
// the engine's result (or a timeout) to the host as a one-cycle pulse.
module sme_host_feeder #(
  parameter int STR_MAX = sme_pkg::STR_MAX,
  parameter int PAT_MAX = sme_pkg::PAT_MAX,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ld_we,
  input  logic       i_ld_sel,
  input  logic [4:0] i_ld_addr,
  input  logic [7:0] i_ld_data,
  input  logic [5:0] i_str_len,
  input  logic [3:0] i_pat_len,
  input  logic       i_send_str,
  input  logic       i_start,
  output logic       o_busy,
  output logic       o_cmd_err,
  output logic [7:0] o_chardata,
  output logic       o_isstring,
  output logic       o_ispattern,
  input  logic       i_sme_valid,
  input  logic       i_sme_match,
  input  logic [4:0] i_sme_match_index,
  output logic       o_res_valid,
  output logic       o_res_match,
  output logic [4:0] o_res_index,
  output logic       o_res_timeout
);
  import sme_pkg::*;

  localparam int STR_AW = $clog2(STR_MAX);
  localparam int PAT_AW = $clog2(PAT_MAX);

  state_t          r_state;
  logic [5:0]      r_cnt;
  logic [5:0]      r_str_len;
  logic [3:0]      r_pat_len;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_str_loaded;

  logic [7:0] w_str_char;
  logic [7:0] w_pat_char;
  logic       w_cmd_bad;
  logic       w_str_we;
  logic       w_pat_we;

  assign w_str_we = i_ld_we & ~i_ld_sel & ~o_busy;
  assign w_pat_we = i_ld_we &  i_ld_sel & ~o_busy;

  sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
    .clk     (clk),
    .i_we    (w_str_we),
    .i_waddr (i_ld_addr[STR_AW-1:0]),
    .i_wdata (i_ld_data),
    .i_raddr (r_cnt[STR_AW-1:0]),
    .o_rdata (w_str_char)
  );

  sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
    .clk     (clk),
    .i_we    (w_pat_we),
    .i_waddr (i_ld_addr[PAT_AW-1:0]),
    .i_wdata (i_ld_data),
    .i_raddr (r_cnt[PAT_AW-1:0]),
    .o_rdata (w_pat_char)
  );

  // A pattern-only command is meaningless until the engine has seen a string.
  assign w_cmd_bad = (i_pat_len == 4'd0) || (i_pat_len > 4'(PAT_MAX)) ||
                     (i_send_str ? ((i_str_len == 6'd0) || (i_str_len > 6'(STR_MAX)))
                                 : ~r_str_loaded);

  // res_valid is a single-cycle strobe; res_match/index/timeout stay valid until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_str_len     <= '0;
      r_pat_len     <= '0;
      r_to_cnt      <= '0;
      r_str_loaded  <= 1'b0;
      o_busy        <= 1'b0;
      o_cmd_err     <= 1'b0;
      o_chardata    <= '0;
      o_isstring    <= 1'b0;
      o_ispattern   <= 1'b0;
      o_res_valid   <= 1'b0;
      o_res_match   <= 1'b0;
      o_res_index   <= '0;
      o_res_timeout <= 1'b0;
    end else begin
      o_cmd_err   <= 1'b0;
      o_res_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_RESULT: begin
          o_isstring  <= 1'b0;
          o_ispattern <= 1'b0;
          o_chardata  <= '0;
          r_state     <= S_IDLE;
          if (i_start) begin
            if (w_cmd_bad) begin
              o_cmd_err <= 1'b1;
            end else begin
              r_str_len <= i_str_len;
              r_pat_len <= i_pat_len;
              r_cnt     <= '0;
              o_busy    <= 1'b1;
              r_state   <= i_send_str ? S_SEND_STR : S_SEND_PAT;
            end
          end
        end
        S_SEND_STR: begin
          o_isstring  <= 1'b1;
          o_ispattern <= 1'b0;
          o_chardata  <= w_str_char;
          if (r_cnt == r_str_len - 6'd1) begin
            r_cnt        <= '0;
            r_str_loaded <= 1'b1;
            r_state      <= S_SEND_PAT;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_SEND_PAT: begin
          // One extra pass after the last char clears the bus so WAIT begins on an idle bus.
          if (r_cnt == {2'b00, r_pat_len}) begin
            o_isstring  <= 1'b0;
            o_ispattern <= 1'b0;
            o_chardata  <= '0;
            r_to_cnt    <= '0;
            r_state     <= S_WAIT;
          end else begin
            o_isstring  <= 1'b0;
            o_ispattern <= 1'b1;
            o_chardata  <= w_pat_char;
            r_cnt       <= r_cnt + 6'd1;
          end
        end
        S_WAIT: begin
          if (i_sme_valid) begin
            o_res_valid   <= 1'b1;
            o_res_match   <= i_sme_match;
            o_res_index   <= i_sme_match ? i_sme_match_index : 5'd0;
            o_res_timeout <= 1'b0;
            o_busy        <= 1'b0;
            r_state       <= S_RESULT;
          end else if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
            o_res_valid   <= 1'b1;
            o_res_match   <= 1'b0;
            o_res_index   <= 5'd0;
            o_res_timeout <= 1'b1;
            o_busy        <= 1'b0;
            r_state       <= S_RESULT;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sme_host_feeder.sv
// Randomized scoreboard bench for sme_host_feeder with a cycle-stamped reference stream.
module tb_sme_host_feeder;
  import sme_pkg::*;

  localparam int CW = 43;  // {cycle, busy, isstring, ispattern, chardata}
  localparam int RW = 40;  // {cycle, busy, match, index, timeout}
  localparam int EW = 33;  // {cycle, busy}
  localparam int TMO = 1023;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_ld_we, i_ld_sel, i_send_str, i_start;
  logic [4:0] i_ld_addr;
  logic [7:0] i_ld_data;
  logic [5:0] i_str_len;
  logic [3:0] i_pat_len;
  logic       i_sme_valid, i_sme_match;
  logic [4:0] i_sme_match_index;
  logic       o_busy, o_cmd_err, o_isstring, o_ispattern;
  logic [7:0] o_chardata;
  logic       o_res_valid, o_res_match, o_res_timeout;
  logic [4:0] o_res_index;

  logic [31:0] cyc = '0;
  int checks = 0;
  int failures = 0;

  logic [CW-1:0] exp_char_q[$];
  logic [RW-1:0] exp_res_q[$];
  logic [EW-1:0] exp_err_q[$];

  logic [7:0] m_str [32];
  logic [7:0] m_pat [8];
  bit         m_str_loaded;

  sme_host_feeder dut (
    .clk(clk), .reset(reset),
    .i_ld_we(i_ld_we), .i_ld_sel(i_ld_sel), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
    .i_str_len(i_str_len), .i_pat_len(i_pat_len), .i_send_str(i_send_str), .i_start(i_start),
    .o_busy(o_busy), .o_cmd_err(o_cmd_err), .o_chardata(o_chardata),
    .o_isstring(o_isstring), .o_ispattern(o_ispattern),
    .i_sme_valid(i_sme_valid), .i_sme_match(i_sme_match), .i_sme_match_index(i_sme_match_index),
    .o_res_valid(o_res_valid), .o_res_match(o_res_match), .o_res_index(o_res_index),
    .o_res_timeout(o_res_timeout)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d (required: completion)", cyc);
    $fatal(1, "watchdog");
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      logic [CW-1:0] ec;
      logic [RW-1:0] er;
      logic [EW-1:0] ee;
      checks++;
      if (o_isstring && o_ispattern) begin
        failures++;
        $display("FAIL strobe_overlap cyc=%0d got both high required exclusive", cyc);
      end
      if (o_isstring || o_ispattern) begin
        checks++;
        if (exp_char_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_char cyc=%0d got s=%b p=%b ch=%h required no strobe",
                   cyc, o_isstring, o_ispattern, o_chardata);
        end else begin
          ec = exp_char_q.pop_front();
          if ({cyc, o_busy, o_isstring, o_ispattern, o_chardata} !== ec) begin
            failures++;
            $display("FAIL char_stream got cyc=%0d busy=%b s=%b p=%b ch=%h required cyc=%0d busy=%b s=%b p=%b ch=%h",
                     cyc, o_busy, o_isstring, o_ispattern, o_chardata,
                     ec[42:11], ec[10], ec[9], ec[8], ec[7:0]);
          end
        end
      end else if (o_chardata !== 8'h00) begin
        failures++;
        $display("FAIL idle_chardata cyc=%0d got %h required 00", cyc, o_chardata);
      end
      if (o_res_valid) begin
        checks++;
        if (exp_res_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result cyc=%0d got m=%b i=%0d t=%b required none",
                   cyc, o_res_match, o_res_index, o_res_timeout);
        end else begin
          er = exp_res_q.pop_front();
          if ({cyc, o_busy, o_res_match, o_res_index, o_res_timeout} !== er) begin
            failures++;
            $display("FAIL result got cyc=%0d busy=%b m=%b i=%0d t=%b required cyc=%0d busy=%b m=%b i=%0d t=%b",
                     cyc, o_busy, o_res_match, o_res_index, o_res_timeout,
                     er[39:8], er[7], er[6], er[5:1], er[0]);
          end
        end
      end
      if (o_cmd_err) begin
        checks++;
        if (exp_err_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_cmd_err cyc=%0d got 1 required 0", cyc);
        end else begin
          ee = exp_err_q.pop_front();
          if ({cyc, o_busy} !== ee) begin
            failures++;
            $display("FAIL cmd_err got cyc=%0d busy=%b required cyc=%0d busy=%b",
                     cyc, o_busy, ee[32:1], ee[0]);
          end
        end
      end
    end
  end

  // driver tasks
  function automatic logic [7:0] rand_char();
    logic [7:0] sp [5];
    sp = '{TRIANGLE, MONEY, DOT, STAR, SPACE};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return 8'($urandom_range(97, 122));
  endfunction

  task automatic load_buf(input bit sel, input logic [4:0] a, input logic [7:0] dt);
    @(negedge clk);
    i_ld_we = 1'b1; i_ld_sel = sel; i_ld_addr = a; i_ld_data = dt;
    @(negedge clk);
    i_ld_we = 1'b0;
    if (sel) m_pat[a[2:0]] = dt; else m_str[a] = dt;
  endtask

  task automatic check_drained(input string tag);
    checks++;
    if (exp_char_q.size() != 0 || exp_res_q.size() != 0 || exp_err_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got pending chars=%0d res=%0d err=%0d required 0 0 0",
               tag, exp_char_q.size(), exp_res_q.size(), exp_err_q.size());
      exp_char_q.delete(); exp_res_q.delete(); exp_err_q.delete();
    end
  endtask

  // d < 0: engine never answers. reset_at > 0: reset is pulsed that many cycles after start.
  task automatic run_txn(input bit ss, input int slen, input int plen, input int d,
                         input bit m, input logic [4:0] idx, input bit disturb, input int reset_at);
    logic [31:0] t, base, w, rescyc;
    bit bad;
    @(negedge clk);
    bad = (plen < 1) || (plen > 8) || (ss ? ((slen < 1) || (slen > 32)) : !m_str_loaded);
    i_start = 1'b1; i_send_str = ss; i_str_len = 6'(slen); i_pat_len = 4'(plen);
    t = cyc + 1;
    @(negedge clk);
    i_start = 1'b0;
    if (bad) begin
      exp_err_q.push_back({t, 1'b0});
      repeat (4) @(negedge clk);
      check_drained("reject");
      return;
    end
    if (ss) for (int i = 0; i < slen; i++) exp_char_q.push_back({t + 1 + 32'(i), 3'b110, m_str[i]});
    base = t + 1 + (ss ? 32'(slen) : 32'd0);
    for (int j = 0; j < plen; j++) exp_char_q.push_back({base + 32'(j), 3'b101, m_pat[j]});
    w = base + 32'(plen);
    if (ss) m_str_loaded = 1'b1;
    if (d >= 0) begin
      rescyc = w + 32'(d) + 1;
      exp_res_q.push_back({rescyc, 1'b0, m, (m ? idx : 5'd0), 1'b0});
    end else begin
      rescyc = w + TMO;
      exp_res_q.push_back({rescyc, 1'b0, 1'b0, 5'd0, 1'b1});
    end
    while (cyc < rescyc + 2) begin
      i_ld_we = 1'b0; i_start = 1'b0;
      i_sme_valid = (d >= 0 && cyc == w + 32'(d)) || (cyc == t + 1);
      i_sme_match = (cyc == t + 1) ? 1'b1 : m;
      i_sme_match_index = (cyc == t + 1) ? 5'd31 : idx;
      if (disturb && cyc == t + 2) begin
        i_ld_we = 1'b1; i_ld_sel = 1'($urandom_range(0, 1));
        i_ld_addr = 5'($urandom); i_ld_data = 8'($urandom);
        i_start = 1'b1; i_send_str = 1'b1; i_str_len = 6'd4; i_pat_len = 4'd2;
      end
      if (reset_at > 0 && cyc == t + 32'(reset_at)) begin
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({o_isstring, o_ispattern, o_busy, o_chardata} !== 11'd0) begin
          failures++;
          $display("FAIL async_reset got s=%b p=%b busy=%b ch=%h required all 0",
                   o_isstring, o_ispattern, o_busy, o_chardata);
        end
        exp_char_q.delete(); exp_res_q.delete();
        m_str_loaded = 1'b0;
        i_sme_valid = 1'b0; i_ld_we = 1'b0; i_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      @(negedge clk);
    end
    i_sme_valid = 1'b0;
    check_drained("txn");
  endtask

  initial begin
    reset = 1'b1;
    i_ld_we = 0; i_ld_sel = 0; i_ld_addr = 0; i_ld_data = 0;
    i_str_len = 0; i_pat_len = 0; i_send_str = 0; i_start = 0;
    i_sme_valid = 0; i_sme_match = 0; i_sme_match_index = 0;
    m_str_loaded = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_busy, o_cmd_err, o_chardata, o_isstring, o_ispattern,
         o_res_valid, o_res_match, o_res_index, o_res_timeout} !== 20'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b err=%b ch=%h s=%b p=%b rv=%b rm=%b ri=%0d rt=%b required all 0",
               o_busy, o_cmd_err, o_chardata, o_isstring, o_ispattern,
               o_res_valid, o_res_match, o_res_index, o_res_timeout);
    end
    reset = 1'b0;

    for (int i = 0; i < 32; i++) load_buf(1'b0, 5'(i), rand_char());
    for (int i = 0; i < 8; i++)  load_buf(1'b1, 5'(i), rand_char());

    // illegal commands straight after reset
    run_txn(1'b0, 4, 2, 0, 1'b0, 5'd0, 1'b0, 0);
    run_txn(1'b1, 0, 2, 0, 1'b0, 5'd0, 1'b0, 0);
    run_txn(1'b1, 4, 9, 0, 1'b0, 5'd0, 1'b0, 0);
    run_txn(1'b1, 33, 2, 0, 1'b0, 5'd0, 1'b0, 0);

    // "abcd" / "bc", then pattern-only "^a" with a non-match
    load_buf(1'b0, 5'd0, 8'h61); load_buf(1'b0, 5'd1, 8'h62);
    load_buf(1'b0, 5'd2, 8'h63); load_buf(1'b0, 5'd3, 8'h64);
    load_buf(1'b1, 5'd0, 8'h62); load_buf(1'b1, 5'd1, 8'h63);
    run_txn(1'b1, 4, 2, 3, 1'b1, 5'd1, 1'b0, 0);
    load_buf(1'b1, 5'd0, TRIANGLE); load_buf(1'b1, 5'd1, 8'h61);
    run_txn(1'b0, 0, 2, 0, 1'b0, 5'd7, 1'b0, 0);

    // timeout, and a response landing on the timeout cycle
    run_txn(1'b1, 4, 2, -1, 1'b1, 5'd3, 1'b0, 0);
    run_txn(1'b0, 0, 2, TMO - 1, 1'b1, 5'd9, 1'b0, 0);

    // full lengths with mid-transfer start/ld_we, then replay to confirm buffers
    run_txn(1'b1, 32, 8, 5, 1'b1, 5'd17, 1'b1, 0);
    run_txn(1'b1, 32, 8, 2, 1'b0, 5'd3, 1'b0, 0);

    for (int k = 0; k < 12; k++) begin
      int sl, pl;
      repeat ($urandom_range(0, 4)) load_buf(1'($urandom_range(0, 1)), 5'($urandom), rand_char());
      sl = (k % 5 == 4) ? $urandom_range(0, 40) : $urandom_range(1, 32);
      pl = (k % 6 == 5) ? $urandom_range(0, 12) : $urandom_range(1, 8);
      run_txn(1'($urandom_range(0, 1)), sl, pl, $urandom_range(0, 20),
              1'($urandom_range(0, 1)), 5'($urandom), 1'b0, 0);
    end

    // reset mid-string, then pattern-only must be rejected
    run_txn(1'b1, 20, 3, 4, 1'b1, 5'd2, 1'b0, 6);
    run_txn(1'b0, 0, 2, 0, 1'b0, 5'd0, 1'b0, 0);
    run_txn(1'b1, 5, 3, 1, 1'b1, 5'd4, 1'b0, 0);

    repeat (3) @(negedge clk);
    check_drained("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sme_host_feeder.md
Name: sme_host_feeder

Overview:
Host-side driver for the string-matching engine (SME) protocol. Holds one string (≤32 chars) and one pattern (≤8 chars) in local buffers and serializes them onto chardata/isstring/ispattern. It then waits for the engine's valid pulse and returns match/match_index to the host as a one-cycle result, with a timeout guard. It sits between the host/test controller and the SME.

Parameters:
STR_MAX, 32, string buffer depth in characters
PAT_MAX, 8, pattern buffer depth in characters
TIMEOUT, 1023, maximum wait cycles for sme_valid after the last pattern char
TO_W, 10, timeout counter width; must hold TIMEOUT

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
ld_we  in  1  buffer write strobe
ld_sel  in  1  0 = string buffer, 1 = pattern buffer
ld_addr  in  5  char index (pattern uses bits [2:0])
ld_data  in  8  ASCII char
str_len  in  6  string length, 1..32; sampled at start
pat_len  in  4  pattern length, 1..8; sampled at start
send_str  in  1  1 = send string then pattern; 0 = pattern only, reusing the engine's last string
start  in  1  transaction request
busy  out  1  high from the cycle after start is accepted until the result pulse
cmd_err  out  1  one-cycle pulse: start rejected
chardata  out  8  char to SME
isstring  out  1  string char valid
ispattern  out  1  pattern char valid
sme_valid  in  1  SME result strobe
sme_match  in  1  SME match flag
sme_match_index  in  5  SME match position
res_valid  out  1  one-cycle result pulse
res_match  out  1  held until the next res_valid
res_index  out  5  held; 0 when res_match = 0
res_timeout  out  1  held; 1 when the result came from the timeout path

Behaviour:
- Reset is async and active-high; clock is clk. Reset clears all outputs to 0, FSM to IDLE, and str_loaded to 0. Buffer contents are not reset.
- FSM states: IDLE, SEND_STR, SEND_PAT, WAIT, RESULT.
- IDLE, start=1, legal command: latch lengths and send_str. Go to SEND_STR if send_str=1, else SEND_PAT.
- Illegal command: str_len ∉ 1..32 with send_str=1; pat_len ∉ 1..8; or send_str=0 with str_loaded=0. Result: cmd_err pulses the next cycle and the FSM stays in IDLE.
- start outside IDLE is ignored with no cmd_err. ld_we is ignored while busy=1.
- Bus outputs are registered. With start sampled at edge T:
  - First char is on the bus after edge T+1.
  - isstring is high for exactly str_len consecutive cycles, chardata = string[0..len-1].
  - ispattern rises in the cycle immediately after the last string char, with no gap, and stays high for exactly pat_len cycles.
  - isstring and ispattern are never high together.
  - chardata = 8'h00 whenever both strobes are low.
- Pattern chars, including ^ $ . *, are passed through unmodified. The feeder does not interpret them.
- WAIT starts the cycle after the last pattern char, and the timeout counter starts at 0.
- sme_valid=1 in WAIT: capture sme_match and sme_match_index (index forced to 0 if match=0). Go to RESULT.
- Timeout: counter reaches TIMEOUT with no sme_valid. Go to RESULT with res_timeout=1, res_match=0, res_index=0.
- RESULT lasts one cycle: res_valid=1, busy drops the same cycle, then IDLE. A new start may be accepted that same cycle.
- sme_valid outside WAIT is ignored. If sme_valid arrives in the same cycle the timeout is reached, sme_valid wins.
- str_loaded is set when SEND_STR completes and is cleared only by reset.
- Reset mid-transaction: strobes drop immediately (async). The SME sees a truncated stream, and recovery is the host's responsibility.

Decomposition:
- Package sme_pkg holds:
  - char constants TRIANGLE=94, MONEY=36, DOT=46, STAR=42, SPACE=32
  - STR_MAX and PAT_MAX
  - FSM state enum
- Sub-module sme_char_buf: parameterized DEPTH×8 register file with one write port and one async read port, instantiated twice (string and pattern).

Test Plan:
1. Load "abcd", pattern "bc", send_str=1, start → isstring for 4 cycles with 61,62,63,64, then ispattern for 2 cycles with 62,63. Stub responds valid, match=1, idx=1 → res_valid, res_match=1, res_index=1, res_timeout=0.
2. Follow-up with send_str=0, pattern "^a" → no isstring; ispattern for 2 cycles with 5E,61. Stub returns match=0, idx=7 → res_index=0.
3. After reset, send_str=0 start → cmd_err pulse, busy stays 0, no strobes. Also str_len=0 → cmd_err; pat_len=9 → cmd_err.
4. Stub never asserts valid → res_valid exactly 1023 cycles after WAIT entry, with res_timeout=1.
5. Full lengths 32/8 → 32 then 8 strobe cycles back-to-back. start and ld_we mid-transfer are ignored, and buffer readback is unchanged.
6. reset asserted during SEND_STR → isstring, ispattern and busy go to 0 immediately. A fresh send_str=0 start then gives cmd_err.
